// File: rtl/menu_text_ram_if.sv
// Command and read-port bundle for menu_text_ram.
// The renderer and the menu controller drive the master side; the store is the slave.
interface menu_text_ram_if #(
    parameter int unsigned COLS   = 16,
    parameter int unsigned ROWS   = 16,
    parameter int unsigned CODE_W = 7
);
    localparam int unsigned COL_W = $clog2(COLS);
    localparam int unsigned ROW_W = $clog2(ROWS);

    logic [ROW_W+COL_W-1:0] char_xy;
    logic [CODE_W-1:0]      char_code;
    logic                   cmd_valid;
    logic                   cmd_ready;
    logic [1:0]             cmd_op;
    logic [COL_W-1:0]       cmd_x;
    logic [ROW_W-1:0]       cmd_y;
    logic [CODE_W-1:0]      cmd_code;
    logic                   busy;
    logic                   err_oob;

    modport slave (
        input  char_xy, cmd_valid, cmd_op, cmd_x, cmd_y, cmd_code,
        output char_code, cmd_ready, busy, err_oob
    );

    modport master (
        output char_xy, cmd_valid, cmd_op, cmd_x, cmd_y, cmd_code,
        input  char_code, cmd_ready, busy, err_oob
    );
endinterface

// File: rtl/menu_text_ram.sv
// Writable character store for menu/HUD text.
// One registered read port for the char renderer, one write port fed by single-cell
// writes or by a row/screen fill sequencer. Reset runs a full-screen fill (INIT).
module menu_text_ram #(
    parameter int unsigned      COLS      = 16,
    parameter int unsigned      ROWS      = 16,
    parameter int unsigned      CODE_W    = 7,
    parameter logic [CODE_W-1:0] FILL_CODE = 'h20
) (
    input  logic            clk,
    input  logic            rst,
    menu_text_ram_if.slave  bus
);
    localparam int unsigned COL_W = $clog2(COLS);
    localparam int unsigned ROW_W = $clog2(ROWS);
    localparam int unsigned DEPTH = COLS * ROWS;
    localparam int unsigned AW    = $clog2(DEPTH);

    // One extra bit so the limits themselves are representable.
    localparam logic [COL_W:0] ColsLim = (COL_W+1)'(COLS);
    localparam logic [ROW_W:0] RowsLim = (ROW_W+1)'(ROWS);

    typedef enum logic [1:0] {StInit, StIdle, StFill} state_e;

    state_e             state_q, state_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic [ROW_W-1:0]   last_row_q, last_row_d;
    logic [CODE_W-1:0]  fill_code_q, fill_code_d;
    logic               err_q, err_d;
    logic [CODE_W-1:0]  char_code_q;
    logic [CODE_W-1:0]  mem_q [DEPTH];

    logic               we;
    logic [ROW_W-1:0]   w_row;
    logic [COL_W-1:0]   w_col;
    logic [CODE_W-1:0]  w_data;
    logic               ready;
    logic               last_cell;

    logic [ROW_W-1:0]   rd_row;
    logic [COL_W-1:0]   rd_col;
    logic               rd_in_range;

    function automatic logic [AW-1:0] cell_idx(input logic [ROW_W-1:0] r,
                                               input logic [COL_W-1:0] c);
        return AW'(32'(r) * COLS + 32'(c));
    endfunction

    assign rd_row      = bus.char_xy[ROW_W+COL_W-1:COL_W];
    assign rd_col      = bus.char_xy[COL_W-1:0];
    assign rd_in_range = ({1'b0, rd_row} < RowsLim) && ({1'b0, rd_col} < ColsLim);
    assign last_cell   = (col_q == COL_W'(COLS - 1)) && (row_q == last_row_q);

    // Next-state, write-port and handshake decode.
    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        col_d       = col_q;
        last_row_d  = last_row_q;
        fill_code_d = fill_code_q;
        err_d       = 1'b0;
        we          = 1'b0;
        w_row       = row_q;
        w_col       = col_q;
        w_data      = fill_code_q;
        ready       = 1'b0;

        unique case (state_q)
            StInit, StFill: begin
                we = 1'b1;
                if (last_cell) begin
                    state_d = StIdle;
                end else if (col_q == COL_W'(COLS - 1)) begin
                    col_d = '0;
                    row_d = row_q + ROW_W'(1);
                end else begin
                    col_d = col_q + COL_W'(1);
                end
            end
            StIdle: begin
                ready = 1'b1;
                if (bus.cmd_valid) begin
                    unique case (bus.cmd_op)
                        2'b00: begin
                            if (({1'b0, bus.cmd_x} < ColsLim) &&
                                ({1'b0, bus.cmd_y} < RowsLim)) begin
                                we     = 1'b1;
                                w_row  = bus.cmd_y;
                                w_col  = bus.cmd_x;
                                w_data = bus.cmd_code;
                            end else begin
                                err_d = 1'b1;
                            end
                        end
                        2'b01: begin
                            if ({1'b0, bus.cmd_y} < RowsLim) begin
                                row_d       = bus.cmd_y;
                                col_d       = '0;
                                last_row_d  = bus.cmd_y;
                                fill_code_d = bus.cmd_code;
                                state_d     = StFill;
                            end else begin
                                err_d = 1'b1;
                            end
                        end
                        2'b10: begin
                            row_d       = '0;
                            col_d       = '0;
                            last_row_d  = ROW_W'(ROWS - 1);
                            fill_code_d = FILL_CODE;
                            state_d     = StFill;
                        end
                        default: ;  // reserved op: accepted and ignored
                    endcase
                end
            end
            default: state_d = StInit;
        endcase
    end

    // Control state; reset restarts a full-screen INIT fill.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StInit;
            row_q       <= '0;
            col_q       <= '0;
            last_row_q  <= ROW_W'(ROWS - 1);
            fill_code_q <= FILL_CODE;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            col_q       <= col_d;
            last_row_q  <= last_row_d;
            fill_code_q <= fill_code_d;
            err_q       <= err_d;
        end
    end

    // Registered read; nonblocking update gives read-before-write on a shared cell.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            char_code_q <= FILL_CODE;
        end else begin
            char_code_q <= rd_in_range ? mem_q[cell_idx(rd_row, rd_col)] : FILL_CODE;
        end
    end

    // Storage array has no reset; INIT writes every cell instead.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[cell_idx(w_row, w_col)] <= w_data;
        end
    end

    assign bus.char_code = char_code_q;
    assign bus.cmd_ready = ready;
    assign bus.busy      = ~ready;
    assign bus.err_oob   = err_q;
endmodule

// File: tb/tb_menu_text_ram.sv
// Bench for menu_text_ram: randomized commands on a 16x16 store checked by a
// queue-based scoreboard, plus directed range checks on a 20x12 store.
module tb_menu_text_ram;
    logic clk;
    logic rst;
    logic rst_b;
    int   n_checks;
    int   n_err;
    bit   done_b;

    menu_text_ram_if #(.COLS(16), .ROWS(16), .CODE_W(7)) bus ();
    menu_text_ram_if #(.COLS(20), .ROWS(12), .CODE_W(7)) bus_b ();

    menu_text_ram #(.COLS(16), .ROWS(16), .CODE_W(7), .FILL_CODE(7'h20)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    menu_text_ram #(.COLS(20), .ROWS(12), .CODE_W(7), .FILL_CODE(7'h20)) u_dut_b (
        .clk (clk),
        .rst (rst_b),
        .bus (bus_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: cell array plus a queue of pending sequencer writes.
    typedef struct { logic [6:0] code; bit chk; bit ready; bit err; } exp_t;
    typedef struct { int idx; logic [6:0] code; } wr_t;

    exp_t       sb[$];
    wr_t        pend[$];
    logic [6:0] mem_m [256];
    bit         known_m [256];

    // One clock of stimulus, starting and ending on a falling edge.
    task automatic step(input bit v, input logic [1:0] op, input logic [3:0] x,
                        input logic [3:0] y, input logic [6:0] code, input logic [7:0] xy);
        exp_t e;
        wr_t  w;
        bus.cmd_valid = v;
        bus.cmd_op    = op;
        bus.cmd_x     = x;
        bus.cmd_y     = y;
        bus.cmd_code  = code;
        bus.char_xy   = xy;
        e.code = mem_m[xy];
        e.chk  = known_m[xy];
        e.err  = 1'b0;
        if (pend.size() != 0) begin
            w = pend.pop_front();
            mem_m[w.idx]   = w.code;
            known_m[w.idx] = 1'b1;
        end else if (v) begin
            case (op)
                2'b00: begin
                    mem_m[int'(y) * 16 + int'(x)]   = code;
                    known_m[int'(y) * 16 + int'(x)] = 1'b1;
                end
                2'b01: for (int c = 0; c < 16; c++) pend.push_back('{int'(y) * 16 + c, code});
                2'b10: for (int i = 0; i < 256; i++) pend.push_back('{i, 7'h20});
                default: ;
            endcase
        end
        e.ready = (pend.size() == 0);
        sb.push_back(e);
        @(negedge clk);
    endtask

    task automatic rd(input logic [7:0] xy);
        step(1'b0, 2'b00, 4'h0, 4'h0, 7'h00, xy);
    endtask

    // Asserts reset on a falling edge, checks the immediate reset values, releases later.
    task automatic do_reset(input int hold);
        rst = 1'b1;
        sb.delete();
        pend.delete();
        for (int i = 0; i < 256; i++) pend.push_back('{i, 7'h20});
        #1;
        chk("rst_code", 32'(bus.char_code), 32'h20);
        chk("rst_ready", 32'(bus.cmd_ready), 32'h0);
        chk("rst_busy", 32'(bus.busy), 32'h1);
        chk("rst_err", 32'(bus.err_oob), 32'h0);
        repeat (hold) @(negedge clk);
        rst = 1'b0;
    endtask

    // Monitor: every output cycle is compared against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                if (e.chk) chk("char_code", 32'(bus.char_code), 32'(e.code));
                chk("cmd_ready", 32'(bus.cmd_ready), 32'(e.ready));
                chk("busy", 32'(bus.busy), 32'(!e.ready));
                chk("err_oob", 32'(bus.err_oob), 32'(e.err));
            end
        end
    end

    // Main 16x16 sequence.
    initial begin
        n_checks = 0;
        n_err    = 0;
        rst      = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'b00;
        bus.cmd_x     = '0;
        bus.cmd_y     = '0;
        bus.cmd_code  = '0;
        bus.char_xy   = '0;
        for (int i = 0; i < 256; i++) known_m[i] = 1'b0;
        @(negedge clk);
        do_reset(2);

        // INIT window with random reads and ignored commands, then sweep all cells.
        for (int i = 0; i < 260; i++)
            step(1'b0, 2'($urandom_range(0, 3)), 4'($urandom), 4'($urandom),
                 7'($urandom), 8'($urandom));
        for (int i = 0; i < 256; i++) rd(8'(i));

        // Single write, neighbour unchanged.
        step(1'b1, 2'b00, 4'd3, 4'd2, 7'h4D, 8'h00);
        rd(8'h23);
        rd(8'h24);

        // Same-edge read and write of one cell returns the old value first.
        step(1'b1, 2'b00, 4'd1, 4'd1, 7'h41, 8'h11);
        rd(8'h11);

        // Row fill, reading around it while it runs and after.
        step(1'b1, 2'b01, 4'd0, 4'd5, 7'h30, 8'h50);
        for (int i = 0; i < 20; i++)
            rd({4'(4 + $urandom_range(0, 2)), 4'($urandom_range(0, 15))});
        for (int i = 0; i < 48; i++) rd(8'(64 + i));

        // Random command mix including reserved op and back-to-back writes.
        for (int i = 0; i < 500; i++) begin
            int unsigned r;
            logic [1:0]  op;
            r  = $urandom_range(0, 31);
            op = (r == 0) ? 2'b10 : (r < 4) ? 2'b01 : (r < 6) ? 2'b11 : 2'b00;
            step($urandom_range(0, 2) != 0, op, 4'($urandom), 4'($urandom),
                 7'($urandom), 8'($urandom));
        end
        for (int i = 0; i < 300; i++) rd(8'($urandom));

        // Reset seven cycles into a clear, then a full INIT rerun.
        step(1'b1, 2'b10, 4'h0, 4'h0, 7'h55, 8'h00);
        for (int i = 0; i < 6; i++) rd(8'(i));
        do_reset(2);
        for (int i = 0; i < 258; i++) rd(8'($urandom));
        for (int i = 0; i < 256; i++) rd(8'(i));

        for (int i = 0; i < 2000 && !done_b; i++) @(negedge clk);
        if (!done_b) chk("b_timeout", 32'(done_b), 32'h1);
        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    // Directed range checks on the 20x12 instance.
    initial begin
        logic [3:0] rr [7];
        logic [4:0] cc [7];
        logic [6:0] ee [7];
        done_b          = 1'b0;
        rst_b           = 1'b0;
        bus_b.cmd_valid = 1'b0;
        bus_b.cmd_op    = 2'b00;
        bus_b.cmd_x     = '0;
        bus_b.cmd_y     = '0;
        bus_b.cmd_code  = '0;
        bus_b.char_xy   = '0;
        @(negedge clk);
        rst_b = 1'b1;
        @(negedge clk);
        rst_b = 1'b0;
        repeat (239) @(negedge clk);
        chk("b_init_busy", 32'(bus_b.cmd_ready), 32'h0);
        @(negedge clk);
        chk("b_init_ready", 32'(bus_b.cmd_ready), 32'h1);

        bus_b.cmd_valid = 1'b1;
        bus_b.cmd_op    = 2'b00;
        bus_b.cmd_x     = 5'd5;
        bus_b.cmd_y     = 4'd3;
        bus_b.cmd_code  = 7'h55;
        @(negedge clk);
        chk("b_wr_err", 32'(bus_b.err_oob), 32'h0);
        bus_b.cmd_x    = 5'd20;
        bus_b.cmd_code = 7'h66;
        @(negedge clk);
        bus_b.cmd_valid = 1'b0;
        chk("b_oobx_err", 32'(bus_b.err_oob), 32'h1);
        chk("b_oobx_ready", 32'(bus_b.cmd_ready), 32'h1);
        @(negedge clk);
        chk("b_err_pulse", 32'(bus_b.err_oob), 32'h0);
        bus_b.cmd_valid = 1'b1;
        bus_b.cmd_op    = 2'b01;
        bus_b.cmd_y     = 4'd12;
        @(negedge clk);
        bus_b.cmd_valid = 1'b0;
        chk("b_oobrow_err", 32'(bus_b.err_oob), 32'h1);
        chk("b_oobrow_ready", 32'(bus_b.cmd_ready), 32'h1);

        rr = '{4'd3, 4'd4, 4'd3, 4'd3, 4'd12, 4'd3, 4'd11};
        cc = '{5'd5, 5'd0, 5'd20, 5'd25, 5'd0, 5'd4, 5'd19};
        ee = '{7'h55, 7'h20, 7'h20, 7'h20, 7'h20, 7'h20, 7'h20};
        for (int i = 0; i < 7; i++) begin
            bus_b.char_xy = {rr[i], cc[i]};
            @(negedge clk);
            chk("b_read", 32'(bus_b.char_code), 32'(ee[i]));
        end
        done_b = 1'b1;
    end
endmodule
